// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// control-field encodings and the decoded-instruction bundle.
package mc_ctrl_pkg;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLh    = 6'h21;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSh    = 6'h29;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluOr  = 4'b0010;
  localparam logic [3:0] AluCmp = 4'b0011;
  localparam logic [3:0] AluSll = 4'b0100;

  localparam logic [1:0] ExtZero = 2'b00;
  localparam logic [1:0] ExtSign = 2'b01;
  localparam logic [1:0] ExtLui  = 2'b10;

  localparam logic [1:0] JmpNone = 2'b00;
  localparam logic [1:0] JmpJ    = 2'b01;
  localparam logic [1:0] JmpJal  = 2'b10;
  localparam logic [1:0] JmpJr   = 2'b11;

  localparam logic [2:0] LdWord = 3'b000;
  localparam logic [2:0] LdByte = 3'b001;
  localparam logic [2:0] LdHalf = 3'b010;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  typedef enum logic [2:0] {
    ClsNop, ClsIllegal, ClsJump, ClsBranch, ClsAlu, ClsLoad, ClsStore
  } instr_cls_e;

  typedef enum logic [1:0] {SzWord, SzHalf, SzByte} mem_size_e;

  typedef struct packed {
    instr_cls_e cls;
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] jump;
    logic [2:0] load_op;
    mem_size_e  size;
  } dec_t;

  function automatic logic [3:0] store_be(input mem_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SzWord:  be = 4'b1111;
      SzHalf:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SzByte:  be = 4'b0001 << addr_lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the IR and produces the static
// control fields the FSM gates by state.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];

  always_comb begin
    dec_o      = '0;
    dec_o.cls  = ClsIllegal;
    dec_o.size = SzWord;
    if (instr_i == 32'h0) begin
      dec_o.cls = ClsNop;
    end else begin
      case (op)
        OpRtype: begin
          case (funct)
            FnAdd: begin
              dec_o.cls     = ClsAlu;
              dec_o.alu_op  = AluAdd;
              dec_o.reg_dst = RegDstRd;
            end
            FnSub: begin
              dec_o.cls     = ClsAlu;
              dec_o.alu_op  = AluSub;
              dec_o.reg_dst = RegDstRd;
            end
            FnSll: begin
              dec_o.cls     = ClsAlu;
              dec_o.alu_op  = AluSll;
              dec_o.reg_dst = RegDstRd;
            end
            FnJr: begin
              dec_o.cls  = ClsJump;
              dec_o.jump = JmpJr;
            end
            default: ;
          endcase
        end
        OpJ: begin
          dec_o.cls  = ClsJump;
          dec_o.jump = JmpJ;
        end
        OpJal: begin
          dec_o.cls     = ClsJump;
          dec_o.jump    = JmpJal;
          dec_o.reg_dst = RegDstRa;
        end
        OpBeq: begin
          dec_o.cls    = ClsBranch;
          dec_o.alu_op = AluCmp;
          dec_o.ext_op = ExtSign;
        end
        OpOri: begin
          dec_o.cls     = ClsAlu;
          dec_o.alu_op  = AluOr;
          dec_o.alu_src = 1'b1;
          dec_o.ext_op  = ExtZero;
        end
        OpLui: begin
          dec_o.cls     = ClsAlu;
          dec_o.alu_op  = AluAdd;
          dec_o.alu_src = 1'b1;
          dec_o.ext_op  = ExtLui;
        end
        OpLw, OpLh, OpLb: begin
          dec_o.cls     = ClsLoad;
          dec_o.alu_op  = AluAdd;
          dec_o.alu_src = 1'b1;
          dec_o.ext_op  = ExtSign;
          dec_o.load_op = (op == OpLw) ? LdWord : (op == OpLh) ? LdHalf : LdByte;
          dec_o.size    = (op == OpLw) ? SzWord : (op == OpLh) ? SzHalf : SzByte;
        end
        OpSw, OpSh, OpSb: begin
          dec_o.cls     = ClsStore;
          dec_o.alu_op  = AluAdd;
          dec_o.alu_src = 1'b1;
          dec_o.ext_op  = ExtSign;
          dec_o.size    = (op == OpSw) ? SzWord : (op == OpSh) ? SzHalf : SzByte;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a memory
// request/ready handshake, wait timeout, store byte enables and error pulses.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic [1:0]  addr_lo,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic        mem_to_reg,
  output logic [2:0]  load_op,
  output logic        branch,
  output logic [1:0]  jump,
  output logic        illegal_instr,
  output logic        align_err,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  dec_t            dec;
  logic            timeout;
  logic            is_load;
  logic            is_store;
  logic            misalign;

  mc_decode u_decode (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign timeout  = (TIMEOUT != 0) && (wait_q == TimeoutVal);
  assign is_load  = (dec.cls == ClsLoad);
  assign is_store = (dec.cls == ClsStore);
  // Loads of a word are not alignment-checked; only sw, sh and lh are.
  assign misalign = (is_store && dec.size == SzWord && addr_lo != 2'b00) ||
                    ((is_store || is_load) && dec.size == SzHalf && addr_lo[0]);

  assign state = reset ? StFetch : state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_be        = 4'b0000;
    reg_write     = 1'b0;
    reg_dst       = RegDstRt;
    alu_src       = 1'b0;
    alu_op        = AluAdd;
    ext_op        = ExtZero;
    mem_to_reg    = 1'b0;
    load_op       = LdWord;
    branch        = 1'b0;
    jump          = JmpNone;
    illegal_instr = 1'b0;
    align_err     = 1'b0;
    bus_err       = 1'b0;

    // Reset forces every output low combinationally, whatever state_q holds.
    if (!reset) begin
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
        alu_src = dec.alu_src;
        alu_op  = dec.alu_op;
        ext_op  = dec.ext_op;
      end

      case (state_q)
        StFetch: begin
          if (timeout) begin
            bus_err = 1'b1;
          end else begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = StDecode;
            end
          end
        end
        StDecode: begin
          state_d = StFetch;
          case (dec.cls)
            ClsNop: ;
            ClsIllegal: illegal_instr = 1'b1;
            ClsJump: begin
              pc_write = 1'b1;
              jump     = dec.jump;
              if (dec.jump == JmpJal) begin
                reg_write = 1'b1;
                reg_dst   = RegDstRa;
              end
            end
            default: state_d = StExec;
          endcase
        end
        StExec: begin
          case (dec.cls)
            ClsBranch: begin
              branch   = 1'b1;
              pc_write = alu_zero;
              state_d  = StFetch;
            end
            ClsAlu:             state_d = StWb;
            ClsLoad, ClsStore:  state_d = StMem;
            default:            state_d = StFetch;
          endcase
        end
        StMem: begin
          if (misalign) begin
            align_err = 1'b1;
            state_d   = StFetch;
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = StFetch;
          end else begin
            mem_req = 1'b1;
            mem_we  = is_store;
            mem_be  = is_store ? store_be(dec.size, addr_lo) : 4'b0000;
            if (mem_ready) begin
              state_d = is_store ? StFetch : StWb;
            end
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          reg_dst    = dec.reg_dst;
          mem_to_reg = is_load;
          load_op    = is_load ? dec.load_op : LdWord;
          state_d    = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // A FETCH retry after timeout keeps the state, so the counter is cleared explicitly.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q || timeout) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready && wait_q != '1) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule
